// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, FSM state type and abs helper for the HI/LO mul/div unit.
//   CON_*  : ALU control codes consumed by the unit (1100 mulu, 1101 divu, 1110 mul, 1111 div)
//   stateT : IDLE / CALC / FIX
//   twosAbs: conditional two's-complement negate, supports operand widths up to MAX_W
package muldiv_pkg;
  localparam logic [3:0] CON_MULU = 4'b1100;
  localparam logic [3:0] CON_DIVU = 4'b1101;
  localparam logic [3:0] CON_MUL = 4'b1110;
  localparam logic [3:0] CON_DIV = 4'b1111;
  localparam int MAX_W = 64;
  typedef enum logic [1:0] {IDLE, CALC, FIX} stateT;
  // The low bits of -v do not depend on v's upper bits, so callers zero-extend and truncate.
  function automatic logic [MAX_W-1:0] twosAbs(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one radix-2 shift-add multiply or restoring-divide step per cycle on unsigned operands.
//   clk, rst_n       : clock, synchronous active-low reset
//   load             : capture opA/opB/isDivIn and clear acc/cnt
//   step             : perform one iteration
//   isDivIn          : 1 = divide (opA dividend, opB divisor), 0 = multiply
//   opA, opB         : unsigned operands
//   hiOut, loOut     : product {hi,lo} or {remainder, quotient} after WIDTH steps
//   lastStep         : current step is the WIDTH-th
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             isDivIn,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] hiOut,
  output logic [WIDTH-1:0] loOut,
  output logic             lastStep
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] acc, sr, m, diff;
  logic [WIDTH:0] sum, shl;
  logic [CW-1:0] cnt;
  logic isDiv, borrow;
  // Multiply: acc holds the running upper half, sr shifts multiplier out and product bits in.
  assign sum = {1'b0, acc} + {1'b0, sr[0] ? m : '0};
  // Divide: partial remainder shifted left with the next dividend bit; a kept difference always fits WIDTH bits.
  assign shl = {acc, sr[WIDTH-1]};
  assign borrow = shl < {1'b0, m};
  assign diff = shl[WIDTH-1:0] - m;
  assign hiOut = acc;
  assign loOut = sr;
  assign lastStep = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      sr <= '0;
      m <= '0;
      cnt <= '0;
      isDiv <= 1'b0;
    end else if (load) begin
      acc <= '0;
      sr <= isDivIn ? opA : opB;
      m <= isDivIn ? opB : opA;
      cnt <= '0;
      isDiv <= isDivIn;
    end else if (step) begin
      acc <= isDiv ? (borrow ? shl[WIDTH-1:0] : diff) : sum[WIDTH:1];
      sr <= isDiv ? {sr[WIDTH-2:0], ~borrow} : {sum[0], sr[WIDTH-1:1]};
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative multiply/divide engine with HI/LO registers and pipeline stall.
//   clk, rst_n  : clock, synchronous active-low reset
//   start, con  : launch request and op code (mulu/divu/mul/div)
//   a, b        : rs / rt operands
//   hiloR, hiloS: mfhi/mflo in EX, select HI (1) or LO (0)
//   flush       : abandon in-flight op without touching HI/LO/dz
//   rd_data     : selected HI/LO register
//   busy, stall : op in flight; stall the pipeline if it needs the unit
//   done        : one-cycle pulse after HI/LO update
//   dz          : last launched divide had a zero divisor
// Build option MULDIV_ZERO_SKIP_EN: zero multiply operands or zero divisor jump straight to FIX.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       con,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hiloR,
  input  logic             hiloS,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dz
);
  stateT state, stateNext;
  logic [WIDTH-1:0] hi, lo, aRaw, iterHi, iterLo, hiNew, loNew;
  logic [2*WIDTH-1:0] prod;
  logic isDivIn, isSgnIn, sA, sB, launch, skip, lastStep, isDiv, negQ, negR, zeroMul;
  assign isDivIn = con == CON_DIVU || con == CON_DIV;
  assign isSgnIn = con == CON_MUL || con == CON_DIV;
  assign sA = isSgnIn & a[WIDTH-1];
  assign sB = isSgnIn & b[WIDTH-1];
  assign launch = state == IDLE && start && !flush && con[3:2] == 2'b11;
`ifdef MULDIV_ZERO_SKIP_EN
  assign skip = isDivIn ? b == '0 : (a == '0 || b == '0);
`else
  assign skip = 1'b0;
`endif
  muldiv_iter #(.WIDTH(WIDTH)) uIter (
    .clk(clk),
    .rst_n(rst_n),
    .load(launch),
    .step(state == CALC),
    .isDivIn(isDivIn),
    .opA(WIDTH'(twosAbs(MAX_W'(a), sA))),
    .opB(WIDTH'(twosAbs(MAX_W'(b), sB))),
    .hiOut(iterHi),
    .loOut(iterLo),
    .lastStep(lastStep)
  );
  assign prod = negQ ? -{iterHi, iterLo} : {iterHi, iterLo};
  // Zero divisor reports the raw dividend in HI (|a| re-signed is a itself) with no sign fix on LO.
  assign hiNew = zeroMul ? '0 : dz ? aRaw : isDiv ? (negR ? -iterHi : iterHi) : prod[2*WIDTH-1:WIDTH];
  assign loNew = zeroMul ? '0 : dz ? '1 : isDiv ? (negQ ? -iterLo : iterLo) : prod[WIDTH-1:0];
  always_comb begin
    stateNext = flush ? IDLE : state == IDLE ? (launch ? (skip ? FIX : CALC) : IDLE) : state == CALC ? (lastStep ? FIX : CALC) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      hi <= '0;
      lo <= '0;
      aRaw <= '0;
      done <= 1'b0;
      dz <= 1'b0;
      isDiv <= 1'b0;
      negQ <= 1'b0;
      negR <= 1'b0;
      zeroMul <= 1'b0;
    end else begin
      state <= stateNext;
      done <= state == FIX && !flush;
      if (launch) begin
        isDiv <= isDivIn;
        negQ <= sA ^ sB;
        negR <= sA;
        zeroMul <= skip & !isDivIn;
        aRaw <= a;
        dz <= isDivIn && b == '0;
      end
      if (state == FIX && !flush) begin
        hi <= hiNew;
        lo <= loNew;
      end
    end
  end
  assign busy = state != IDLE;
  assign stall = busy & (start | hiloR);
  assign rd_data = hiloS ? hi : lo;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed self-checking bench for hilo_muldiv_unit (WIDTH=32).
module tb_hilo_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = W + 1;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, hiloR = 1'b0, hiloS = 1'b0, flush = 1'b0;
  logic [3:0] con = 4'b0;
  logic [W-1:0] a = '0, b = '0, rd_data;
  logic busy, stall, done, dz;
  int checks = 0, failures = 0;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .con(con), .a(a), .b(b),
    .hiloR(hiloR), .hiloS(hiloS), .flush(flush),
    .rd_data(rd_data), .busy(busy), .stall(stall), .done(done), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launchOp(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    con = c; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    tick(2);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (dz !== 1'b0) begin failures++; $display("FAIL reset_dz got=%0b exp=0", dz); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    hiloS = 1'b1; #1;
    checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", rd_data); end
    hiloS = 1'b0; #1;
    checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", rd_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mulu;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mulu_idle_busy got=%0b exp=0", busy); end
    launchOp(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mulu_busy_e0 got=%0b exp=1", busy); end
    tick(W);
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL mulu_fix got done=%0b busy=%0b exp done=0 busy=1", done, busy); end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mulu_done got done=%0b busy=%0b exp done=1 busy=0", done, busy); end
    hiloS = 1'b1; #1;
    checks++; if (rd_data !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulu_hi got=%h exp=fffffffe", rd_data); end
    hiloS = 1'b0; #1;
    checks++; if (rd_data !== 32'h0000_0001) begin failures++; $display("FAIL mulu_lo got=%h exp=00000001", rd_data); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mulu_done_pulse got=%0b exp=0", done); end
    launchOp(4'b1100, 32'h1234_5678, 32'h0000_0010);
    tick(W + 1);
    hiloS = 1'b1; #1;
    checks++; if (rd_data !== 32'h0000_0001) begin failures++; $display("FAIL mulu2_hi got=%h exp=00000001", rd_data); end
    hiloS = 1'b0; #1;
    checks++; if (rd_data !== 32'h2345_6780) begin failures++; $display("FAIL mulu2_lo got=%h exp=23456780", rd_data); end
  endtask

  task automatic test_signed;
    launchOp(4'b1110, -32'sd3, 32'd7);
    tick(W + 1);
    hiloS = 1'b1; #1;
    checks++; if (rd_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mul_hi got=%h exp=ffffffff", rd_data); end
    hiloS = 1'b0; #1;
    checks++; if (rd_data !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_lo got=%h exp=ffffffeb", rd_data); end
    launchOp(4'b1111, -32'sd7, 32'd2);
    tick(W + 1);
    hiloS = 1'b1; #1;
    checks++; if (rd_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", rd_data); end
    hiloS = 1'b0; #1;
    checks++; if (rd_data !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", rd_data); end
    launchOp(4'b1101, 32'd100, 32'd7);
    tick(W + 1);
    hiloS = 1'b1; #1;
    checks++; if (rd_data !== 32'd2) begin failures++; $display("FAIL divu_hi got=%h exp=00000002", rd_data); end
    hiloS = 1'b0; #1;
    checks++; if (rd_data !== 32'd14) begin failures++; $display("FAIL divu_lo got=%h exp=0000000e", rd_data); end
  endtask

  task automatic test_divzero;
    launchOp(4'b1101, 32'd5, 32'd0);
    checks++; if (dz !== 1'b1) begin failures++; $display("FAIL dz_flag got=%0b exp=1", dz); end
    tick(ZLAT - 1);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL dz_early_done got=%0b exp=0", done); end
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL dz_done got=%0b exp=1", done); end
    hiloS = 1'b1; #1;
    checks++; if (rd_data !== 32'd5) begin failures++; $display("FAIL divu0_hi got=%h exp=00000005", rd_data); end
    hiloS = 1'b0; #1;
    checks++; if (rd_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu0_lo got=%h exp=ffffffff", rd_data); end
    launchOp(4'b1111, -32'sd8, 32'd0);
    tick(ZLAT);
    hiloS = 1'b1; #1;
    checks++; if (rd_data !== 32'hFFFF_FFF8) begin failures++; $display("FAIL div0_hi got=%h exp=fffffff8", rd_data); end
    hiloS = 1'b0; #1;
    checks++; if (rd_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_lo got=%h exp=ffffffff", rd_data); end
    launchOp(4'b1110, 32'd0, -32'sd5);
    tick(ZLAT);
    checks++; if (done !== 1'b1 || dz !== 1'b0) begin failures++; $display("FAIL mul0_done got done=%0b dz=%0b exp done=1 dz=0", done, dz); end
    hiloS = 1'b1; #1;
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL mul0_hi got=%h exp=00000000", rd_data); end
    hiloS = 1'b0; #1;
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL mul0_lo got=%h exp=00000000", rd_data); end
  endtask

  task automatic test_minneg1;
    launchOp(4'b1111, 32'h8000_0000, 32'hFFFF_FFFF);
    tick(W + 1);
    checks++; if (dz !== 1'b0) begin failures++; $display("FAIL minneg1_dz got=%0b exp=0", dz); end
    hiloS = 1'b1; #1;
    checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL minneg1_hi got=%h exp=00000000", rd_data); end
    hiloS = 1'b0; #1;
    checks++; if (rd_data !== 32'h8000_0000) begin failures++; $display("FAIL minneg1_lo got=%h exp=80000000", rd_data); end
  endtask

  task automatic test_stall;
    hiloR = 1'b1; hiloS = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_idle got=%0b exp=0", stall); end
    launchOp(4'b1100, 32'h0001_0000, 32'h0003_0000);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL stall_e0 got=%0b exp=1", stall); end
    con = 4'b1101; a = 32'd1; b = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(W - 1);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL stall_fix got=%0b exp=1", stall); end
    tick();
    checks++; if (stall !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL stall_release got stall=%0b done=%0b exp stall=0 done=1", stall, done); end
    checks++; if (rd_data !== 32'd3) begin failures++; $display("FAIL stall_rd_hi got=%h exp=00000003", rd_data); end
    hiloR = 1'b0; hiloS = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_start_ignored got busy=%0b exp=0", busy); end
  endtask

  task automatic test_flush;
    logic sawDone;
    launchOp(4'b1101, 32'd100, 32'd7);
    tick(10);
    flush = 1'b1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_pre_busy got=%0b exp=1", busy); end
    tick();
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_idle got=%0b exp=0", busy); end
    sawDone = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      sawDone |= done;
      tick();
    end
    checks++; if (sawDone !== 1'b0) begin failures++; $display("FAIL flush_no_done got=%0b exp=0", sawDone); end
    hiloS = 1'b1; #1;
    checks++; if (rd_data !== 32'd3) begin failures++; $display("FAIL flush_hi got=%h exp=00000003", rd_data); end
    hiloS = 1'b0; #1;
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL flush_lo got=%h exp=00000000", rd_data); end
    flush = 1'b1;
    launchOp(4'b1100, 32'd2, 32'd2);
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_launch got busy=%0b exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    launchOp(4'b1100, 32'd6, 32'd7);
    tick(W + 1);
    checks++; if (done !== 1'b1 || rd_data !== 32'd42) begin failures++; $display("FAIL b2b_first got done=%0b lo=%h exp done=1 lo=0000002a", done, rd_data); end
    launchOp(4'b1101, 32'd100, 32'd7);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got busy=%0b exp=1", busy); end
    tick(W + 1);
    checks++; if (done !== 1'b1 || rd_data !== 32'd14) begin failures++; $display("FAIL b2b_second got done=%0b lo=%h exp done=1 lo=0000000e", done, rd_data); end
  endtask

  task automatic test_reset_midop;
    launchOp(4'b1110, -32'sd3, 32'd7);
    tick(5);
    rst_n = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0) begin failures++; $display("FAIL rstmid_flags got busy=%0b done=%0b dz=%0b exp 0 0 0", busy, done, dz); end
    hiloS = 1'b1; #1;
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL rstmid_hi got=%h exp=00000000", rd_data); end
    hiloS = 1'b0; #1;
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL rstmid_lo got=%h exp=00000000", rd_data); end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_mulu();
    test_signed();
    test_divzero();
    test_minneg1();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Iterative multiply/divide engine with HI/LO register file, sitting in EX directly downstream of the ALU control decoder. It consumes the `con` codes 1100–1111 together with the `hiloW` and `hiloR`/`hiloS` controls, and runs a WIDTH-cycle shift-add multiply or restoring divide. It writes the 2×WIDTH result into HI/LO, serves mfhi/mflo reads, and stalls the pipeline while an operation is in flight.

## Interface
- `WIDTH`, default 32, operand/register width (≥ 4)
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  request to launch an op (hiloW from decoder)
- `con`  in  4  ALU control code: 1100 mulu, 1101 divu, 1110 mul, 1111 div
- `a`  in  WIDTH  rs operand (multiplicand / dividend)
- `b`  in  WIDTH  rt operand (multiplier / divisor)
- `hiloR`  in  1  mfhi/mflo in EX
- `hiloS`  in  1  1 = read HI, 0 = read LO
- `flush`  in  1  kill in-flight op
- `rd_data`  out  WIDTH  hiloS ? HI : LO (combinational from registers)
- `busy`  out  1  state ≠ IDLE
- `stall`  out  1  busy & (start | hiloR)
- `done`  out  1  one-cycle pulse, HI/LO just updated
- `dz`  out  1  last launched divide had zero divisor

## Operation
- Launch: IDLE & start & con[3:2]==11 & !flush. Latches |a|,|b| (signed ops) or raw (unsigned), result sign flags, op type. state←CALC, cnt←0, dz←(divide & b==0).
  - start with other con: ignored.
  - start while busy: ignored (pipeline is stalled by `stall`).
- States:
  - IDLE→CALC on launch.
  - CALC: one radix-2 step per cycle; after WIDTH steps →FIX.
  - FIX: sign correction, HI/LO write, done←1, →IDLE.
- Multiply: 2×WIDTH product; signed negated when a/b signs differ; HI = upper half, LO = lower half.
- Divide, restoring: LO = quotient, HI = remainder.
  - Signed: quotient negated when signs differ; remainder takes dividend's sign.
  - b==0: HI = a, LO = all ones, no sign fix, dz=1.
  - Signed MIN / −1: LO = 0x80..0, HI = 0 (natural result, no trap).
- Flush: any state→IDLE next edge; HI/LO and dz unchanged; no done pulse.
- Flush and launch in the same cycle: flush wins, no launch.
- Reset mid-op: abort; all state cleared.
- Reset values: HI=0, LO=0, state=IDLE, busy=0, done=0, dz=0, stall=0, rd_data=0.

## Timing
- Launch sampled at edge E0. CALC covers E1..E(WIDTH). HI/LO written at edge E(WIDTH+1).
- done is high in the cycle after E(WIDTH+1); busy is high in that cycle's predecessor cycles only.
- busy is high from after E0 through the FIX cycle.
- mfhi/mflo issued during busy stalls. The first non-stalled read returns new HI/LO; no forwarding path needed.
- Back-to-back: a new launch is accepted in the cycle done is high.

## Configuration
- `MULDIV_ZERO_SKIP_EN` defined: if the multiply has a==0 or b==0, or the divide has b==0, launch goes IDLE→FIX directly. Result is identical, written at E1, done in the following cycle.
- Undefined: every op takes the full WIDTH+1 edges.

## Structure
- Package `muldiv_pkg`:
  - con constants `CON_MULU/CON_DIVU/CON_MUL/CON_DIV`
  - state enum `IDLE/CALC/FIX`
  - helper for two's-complement abs
- Sub-module `muldiv_iter`: the per-step shift-add / restore-subtract datapath (acc, quotient/multiplier shift register, cnt).
- HI/LO registers, FSM, flush and read mux stay in the top.

## Test plan
- mulu 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; done at cycle after E33; busy=0 before E0.
- mul −3×7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. div −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 5/0 → HI=5, LO=0xFFFFFFFF, dz=1. With macro, write occurs at E1; without it, at E33.
- div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0, dz=0.
- hiloR=1, hiloS=1 held during op → stall=1 through FIX, then rd_data=new HI; start pulsed while busy → ignored.
- flush at E10 of divide → IDLE at E11, HI/LO retain prior values, no done; rst_n=0 mid-op → HI/LO=0 next edge.
